// File: rtl/cpu_pkg.sv
// Shared core constants: datapath width, PC-select encodings and sequencer states.
package cpu_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PCSEL_NEXT = 2'b00,
    PCSEL_BR   = 2'b01,
    PCSEL_JMP  = 2'b10,
    PCSEL_JR   = 2'b11
  } pc_sel_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC select and adders for the fetch sequencer.
// Optional macro PC_SEQ_BEX_EN: bex with non-zero r30 overrides pc_sel with a jump to target.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_pc_sel,
  input  logic            i_is_bne,
  input  logic            i_is_blt,
  input  logic            i_alu_ne,
  input  logic            i_alu_lt,
  input  logic [16:0]     i_imm,
  input  logic [26:0]     i_target,
  input  logic [XLEN-1:0] i_rd_val,
  input  logic            i_is_bex,
  input  logic            i_rstatus_nz,
  output logic [XLEN-1:0] o_pc_plus1,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_redirect
);
  logic [XLEN-1:0] w_br_off;
  logic [XLEN-1:0] w_jmp;
  logic            w_cond;
  logic            w_bex;

  assign o_pc_plus1 = i_pc + XLEN'(1);
  assign w_br_off   = {{(XLEN-17){i_imm[16]}}, i_imm};
  assign w_jmp      = {{(XLEN-27){1'b0}}, i_target};
  assign w_cond     = (i_is_bne & i_alu_ne) | (i_is_blt & i_alu_lt);

`ifdef PC_SEQ_BEX_EN
  assign w_bex = i_is_bex & i_rstatus_nz;
`else
  logic w_unused_bex;
  assign w_unused_bex = i_is_bex ^ i_rstatus_nz;
  assign w_bex        = 1'b0;
`endif

  always_comb begin
    o_pc_next  = o_pc_plus1;
    o_redirect = 1'b0;
    if (w_bex) begin
      o_pc_next  = w_jmp;
      o_redirect = 1'b1;
    end else begin
      case (pc_sel_e'(i_pc_sel))
        PCSEL_BR: if (w_cond) begin
          o_pc_next  = o_pc_plus1 + w_br_off;
          o_redirect = 1'b1;
        end
        PCSEL_JMP: o_pc_next = w_jmp;
        PCSEL_JR:  o_pc_next = i_rd_val;
        default:   o_pc_next = o_pc_plus1;
      endcase
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// PC register, mult/div stall FSM, retired counter and sticky timeout flag.
// Optional macro PC_SEQ_BEX_EN (see pc_next_calc) enables the bex redirect.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          MD_TIMEOUT = 64,
  parameter int          CNT_W      = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [1:0]       i_pc_sel,
  input  logic             i_is_bne,
  input  logic             i_is_blt,
  input  logic             i_alu_ne,
  input  logic             i_alu_lt,
  input  logic [16:0]      i_imm,
  input  logic [26:0]      i_target,
  input  logic [31:0]      i_rd_val,
  input  logic             i_md_start,
  input  logic             i_md_ready,
  input  logic             i_is_bex,
  input  logic             i_rstatus_nz,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_plus1,
  output logic             o_stall,
  output logic             o_branch_taken,
  output logic             o_md_timeout,
  output logic [CNT_W-1:0] o_retired
);
  localparam int WCW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  state_e           r_state, w_state_nxt;
  logic [XLEN-1:0]  r_pc, w_pc_nxt, w_pc_next, w_pc_plus1;
  logic [WCW-1:0]   r_wcnt, w_wcnt_nxt;
  logic [CNT_W-1:0] r_retired;
  logic             r_branch_taken, r_md_timeout;
  logic             w_redirect, w_bt_nxt, w_ret_inc, w_to_set, w_wcnt_last;

  pc_next_calc u_next (
    .i_pc         (r_pc),
    .i_pc_sel     (i_pc_sel),
    .i_is_bne     (i_is_bne),
    .i_is_blt     (i_is_blt),
    .i_alu_ne     (i_alu_ne),
    .i_alu_lt     (i_alu_lt),
    .i_imm        (i_imm),
    .i_target     (i_target),
    .i_rd_val     (i_rd_val),
    .i_is_bex     (i_is_bex),
    .i_rstatus_nz (i_rstatus_nz),
    .o_pc_plus1   (w_pc_plus1),
    .o_pc_next    (w_pc_next),
    .o_redirect   (w_redirect)
  );

  assign w_wcnt_last = (r_wcnt == WCW'(MD_TIMEOUT - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_PC;
      r_wcnt         <= '0;
      r_retired      <= '0;
      r_branch_taken <= 1'b0;
      r_md_timeout   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_wcnt         <= w_wcnt_nxt;
      r_branch_taken <= w_bt_nxt;
      if (w_ret_inc) r_retired    <= r_retired + CNT_W'(1);
      if (w_to_set)  r_md_timeout <= 1'b1;
    end
  end

  // md_ready is only looked at once the wait state is entered, so the stall is at least one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_wcnt_nxt  = r_wcnt;
    w_bt_nxt    = 1'b0;
    w_ret_inc   = 1'b0;
    w_to_set    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_md_start) begin
          w_state_nxt = ST_MD_WAIT;
          w_wcnt_nxt  = '0;
        end else begin
          w_pc_nxt  = w_pc_next;
          w_bt_nxt  = w_redirect;
          w_ret_inc = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        w_wcnt_nxt = r_wcnt + WCW'(1);
        if (i_md_ready || w_wcnt_last) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = w_pc_plus1;
          w_ret_inc   = 1'b1;
          w_to_set    = ~i_md_ready;
        end
      end
    endcase
  end

  assign o_pc           = r_pc;
  assign o_pc_plus1     = w_pc_plus1;
  assign o_stall        = (r_state == ST_MD_WAIT);
  assign o_branch_taken = r_branch_taken;
  assign o_md_timeout   = r_md_timeout;
  assign o_retired      = r_retired;
endmodule
